bscan_mux_chan: RTL and testbench

- Next-generation JTAG user data-register engine; multiplexes one BSCANE2 USER chain onto CHANNELS independent word channels of WIDTH bits.
- Sits between the BSCANE2/BUFG primitives and user logic.
- CLK is the BUFG-buffered TCK, so all scan signals are synchronous to CLK.
- Each channel has a one-deep tx holding slot (user -> host) and an rx delivery port (host -> user), plus per-channel status.
- One DR scan frame addresses channels through a header and carries one payload word in each direction.

---
 rtl/bscan_mux_pkg.sv | 29 ++
 rtl/bscan_mux_slot.sv | 39 +++
 rtl/bscan_mux_chan.sv | 146 ++++++++++++++
 tb/tb_bscan_mux_chan.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bscan_mux_pkg.sv
// Shared constants and helpers for the JTAG user-register channel mux.
// Header offsets depend on the channel-select width, so they are provided as functions of it.
package bscan_mux_pkg;

  // Captured status header: bit 0 = slot valid, bit 1 = overflow, then cur_ch.
  localparam int ST_VALID = 0;
  localparam int ST_OVF   = 1;
  localparam int ST_CH_LO = 2;

  // Incoming header: channel select starts at bit 0, then write, ack, payload.
  localparam int CH_LO = 0;

  function automatic int ch_bits(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int wr_bit(input int cb);
    return CH_LO + cb;
  endfunction

  function automatic int ack_bit(input int cb);
    return CH_LO + cb + 1;
  endfunction

  function automatic int pay_lo(input int cb);
    return CH_LO + cb + 2;
  endfunction

endpackage

// File: rtl/bscan_mux_slot.sv
// One-deep tx holding slot plus overflow sticky for a single channel.
// The enqueue and pop strobes are qualified by the parent so they never overlap.
module bscan_mux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             pop,
  input  logic             ovf_set,
  input  logic             ovf_clr,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             ovf
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      full <= 1'b0;
      // NOTE: the data word is reset too (it is a single register, not a RAM),
      // so a capture of an empty slot scans out a deterministic payload.
      data <= '0;
      ovf  <= 1'b0;
    end else begin
      if (enq) begin
        full <= 1'b1;
        data <= enq_data;
      end else if (pop) begin
        full <= 1'b0;
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/bscan_mux_chan.sv
// BSCANE2 USER data-register engine multiplexing one scan chain onto CHANNELS word channels.
// Optional frame-length checking is enabled by defining BSCAN_MUX_LEN_CHECK_EN.
module bscan_mux_chan
  import bscan_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  localparam int CH_BITS = ch_bits(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      sel,
  input  logic                      capture,
  input  logic                      shift,
  input  logic                      update,
  input  logic                      tdi,
  output logic                      tdo,
  input  logic [CHANNELS-1:0]       tx_valid,
  input  logic [CHANNELS*WIDTH-1:0] tx_data,
  output logic [CHANNELS-1:0]       tx_ready,
  output logic [CHANNELS-1:0]       rx_valid,
  output logic [WIDTH-1:0]          rx_data,
  input  logic [CHANNELS-1:0]       rx_ready,
  output logic [CH_BITS-1:0]        cur_ch
);

  localparam int HDR_W   = CH_BITS + 2;
  localparam int FRAME_W = HDR_W + WIDTH;
  localparam int WR_BIT  = wr_bit(CH_BITS);
  localparam int ACK_BIT = ack_bit(CH_BITS);
  localparam int PAY_LO  = pay_lo(CH_BITS);

  logic [FRAME_W-1:0]  sr;
  logic [FRAME_W-1:0]  cap_frame;
  logic                cap_valid;
  logic                do_cap, do_shift, do_upd;
  logic                len_ok, in_range, commit;
  logic [CH_BITS-1:0]  hch;
  logic                wr, ack;
  logic [WIDTH-1:0]    pay;

  logic [CHANNELS-1:0] slot_full, slot_ovf;
  logic [CHANNELS-1:0] enq, pop, ovf_set, ovf_clr;
  logic [WIDTH-1:0]    slot_data [CHANNELS];

  assign do_cap   = sel & capture;
  assign do_shift = sel & shift & ~capture;
  assign do_upd   = sel & update;

  assign hch      = sr[CH_LO +: CH_BITS];
  assign wr       = sr[WR_BIT];
  assign ack      = sr[ACK_BIT];
  assign pay      = sr[PAY_LO +: WIDTH];
  assign in_range = 32'(hch) < CHANNELS;
  assign commit   = do_upd & len_ok;

  assign tdo      = sr[0];
  assign tx_ready = ~slot_full;

`ifdef BSCAN_MUX_LEN_CHECK_EN
  // Counts shifted bits since capture; saturating one past FRAME_W keeps
  // over-long scans distinguishable from exact ones.
  localparam int CNT_W = $clog2(FRAME_W + 2);
  logic [CNT_W-1:0] shift_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                                      shift_cnt <= '0;
    else if (do_cap)                                              shift_cnt <= '0;
    else if (do_shift && shift_cnt != CNT_W'(FRAME_W + 1))        shift_cnt <= shift_cnt + CNT_W'(1);
  end

  assign len_ok = (shift_cnt == CNT_W'(FRAME_W));
`else
  assign len_ok = 1'b1;
`endif

  always_comb begin
    cap_frame                     = '0;
    cap_frame[ST_VALID]           = slot_full[cur_ch];
    cap_frame[ST_OVF]             = slot_ovf[cur_ch];
    cap_frame[ST_CH_LO +: CH_BITS] = cur_ch;
    cap_frame[HDR_W +: WIDTH]     = slot_data[cur_ch];
  end

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // bit unassigned and no latch is inferred.
    enq     = '0;
    pop     = '0;
    ovf_set = '0;
    ovf_clr = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      enq[c]     = tx_valid[c] & ~slot_full[c];
      pop[c]     = commit & ack & cap_valid & (cur_ch == CH_BITS'(c));
      ovf_clr[c] = do_cap & (cur_ch == CH_BITS'(c));
      if (commit)
        ovf_set[c] = wr & in_range & (hch == CH_BITS'(c)) & ~rx_ready[c];
      else if (do_upd)
        ovf_set[c] = (cur_ch == CH_BITS'(c));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
    bscan_mux_slot #(.WIDTH(WIDTH)) u_slot (
      .CLK      (CLK),
      .RST      (RST),
      .enq      (enq[g]),
      .enq_data (tx_data[g*WIDTH +: WIDTH]),
      .pop      (pop[g]),
      .ovf_set  (ovf_set[g]),
      .ovf_clr  (ovf_clr[g]),
      .full     (slot_full[g]),
      .data     (slot_data[g]),
      .ovf      (slot_ovf[g])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr        <= '0;
      cur_ch    <= '0;
      cap_valid <= 1'b0;
      rx_valid  <= '0;
      rx_data   <= '0;
    end else begin
      rx_valid <= '0;
      if (do_cap) begin
        sr        <= cap_frame;
        cap_valid <= slot_full[cur_ch];
      end else if (do_shift) begin
        sr <= {tdi, sr[FRAME_W-1:1]};
      end
      if (do_upd) begin
        cap_valid <= 1'b0;
        if (len_ok && in_range) begin
          cur_ch <= hch;
          if (wr && rx_ready[hch]) begin
            rx_valid[hch] <= 1'b1;
            rx_data       <= pay;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bscan_mux_chan.sv
// Self-checking bench for bscan_mux_chan with five channels (so out-of-range selects exist).
// Builds with or without BSCAN_MUX_LEN_CHECK_EN; the reference model follows the same define.
module tb_bscan_mux_chan;

  localparam int W  = 32;
  localparam int N  = 5;
  localparam int CB = 3;
  localparam int FW = CB + 2 + W;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           sel = 1'b0, capture = 1'b0, shift = 1'b0, update = 1'b0, tdi = 1'b0;
  logic           tdo;
  logic [N-1:0]   tx_valid = '0;
  logic [N*W-1:0] tx_data = '0;
  logic [N-1:0]   tx_ready;
  logic [N-1:0]   rx_valid;
  logic [W-1:0]   rx_data;
  logic [N-1:0]   rx_ready = '1;
  logic [CB-1:0]  cur_ch;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: channel slots, stickies and scan bookkeeping.
  bit           full_m [N];
  logic [W-1:0] data_m [N];
  bit           ovf_m  [N];
  int           cur_m;
  bit           capv_m;
  logic [N-1:0] exp_rxv;
  logic [W-1:0] exp_rxd;

  bscan_mux_chan #(.WIDTH(W), .CHANNELS(N)) dut (
    .CLK(CLK), .RST(RST), .sel(sel), .capture(capture), .shift(shift), .update(update),
    .tdi(tdi), .tdo(tdo), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .cur_ch(cur_ch)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [N-1:0] exp_txr();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = !full_m[c];
    return r;
  endfunction

  function automatic logic [FW-1:0] mk_frame(input int hch, input bit wr, input bit ack, input logic [W-1:0] pay);
    return {pay, ack, wr, 3'(hch)};
  endfunction

  task automatic reset_model();
    for (int c = 0; c < N; c++) begin
      full_m[c] = 0; data_m[c] = '0; ovf_m[c] = 0;
    end
    cur_m = 0; capv_m = 0; exp_rxv = '0; exp_rxd = '0;
  endtask

  task automatic enqueue(input int c, input logic [W-1:0] d);
    tx_valid[c] = 1'b1;
    tx_data[c*W +: W] = d;
    tick();
    tx_valid = '0;
    if (!full_m[c]) begin
      full_m[c] = 1; data_m[c] = d;
    end
  endtask

  // One capture / nbits shifts / update sequence. Returns the observed tdo stream,
  // the model's expected captured frame and a mask of the bits worth comparing.
  task automatic do_scan(input logic [FW-1:0] frame, input int nbits, input bit sel_v,
                         input logic [N-1:0] enq_mask, input logic [W-1:0] enq_d,
                         output logic [FW-1:0] got, output logic [FW-1:0] exp_cap,
                         output logic [FW-1:0] msk);
    logic [FW-1:0] sr_m;
    logic [CB-1:0] hch;
    bit            ok;
    int            h;
    got = '0; msk = '0; exp_cap = '0;
    exp_cap[0]          = full_m[cur_m];
    exp_cap[1]          = ovf_m[cur_m];
    exp_cap[4:2]        = 3'(cur_m);
    exp_cap[FW-1:CB+2]  = data_m[cur_m];
    sel = sel_v;
    capture = 1'b1; tx_valid = enq_mask; tx_data = {N{enq_d}};
    tick();
    capture = 1'b0; tx_valid = '0;
    if (sel_v) begin
      ovf_m[cur_m] = 0;
      capv_m = full_m[cur_m];
    end
    for (int c = 0; c < N; c++)
      if (enq_mask[c] && !full_m[c]) begin
        full_m[c] = 1; data_m[c] = enq_d;
      end
    sr_m = exp_cap;
    shift = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      tdi = (k < FW) ? frame[k] : 1'b0;
      if (k < FW) begin
        got[k] = tdo;
        msk[k] = sel_v;
      end
      sr_m = {tdi, sr_m[FW-1:1]};
      tick();
    end
    shift = 1'b0;
    update = 1'b1;
    tick();
    update = 1'b0; sel = 1'b0;
    if (!exp_cap[0]) msk[FW-1:CB+2] = '0;
    exp_rxv = '0;
    if (sel_v) begin
`ifdef BSCAN_MUX_LEN_CHECK_EN
      ok = (nbits == FW);
`else
      ok = 1;
`endif
      hch = sr_m[2:0];
      h = int'(hch);
      if (ok) begin
        if (sr_m[3] && h < N) begin
          if (rx_ready[h]) begin
            exp_rxv[h] = 1'b1; exp_rxd = sr_m[FW-1:CB+2];
          end else begin
            ovf_m[h] = 1;
          end
        end
        if (sr_m[4] && capv_m) full_m[cur_m] = 0;
        if (h < N) cur_m = h;
      end else begin
        ovf_m[cur_m] = 1;
      end
      capv_m = 0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    reset_model();
    n_tests++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo got=%b exp=0", tdo); end
    n_tests++; if (tx_ready !== '1) begin n_fail++; $display("FAIL reset_tx_ready got=%b exp=%b", tx_ready, 5'b11111); end
    n_tests++; if (cur_ch !== '0) begin n_fail++; $display("FAIL reset_cur_ch got=%0d exp=0", cur_ch); end
    n_tests++; if (rx_valid !== '0 || rx_data !== '0) begin n_fail++; $display("FAIL reset_rx got=%b/%h exp=0/0", rx_valid, rx_data); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_write_deliver();
    logic [FW-1:0] got, exp_cap, msk;
    rx_ready = '1;
    do_scan(mk_frame(2, 1, 0, 32'hDEADBEEF), FW, 1, '0, '0, got, exp_cap, msk);
    n_tests++; if (rx_valid !== 5'b00100 || rx_valid !== exp_rxv) begin n_fail++; $display("FAIL deliver_rx_valid got=%b exp=%b", rx_valid, exp_rxv); end
    n_tests++; if (rx_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL deliver_rx_data got=%h exp=deadbeef", rx_data); end
    n_tests++; if (int'(cur_ch) != cur_m || cur_m != 2) begin n_fail++; $display("FAIL deliver_cur_ch got=%0d exp=%0d", cur_ch, cur_m); end
    tick();
    n_tests++; if (rx_valid !== '0) begin n_fail++; $display("FAIL deliver_pulse_width got=%b exp=0", rx_valid); end
  endtask

  task automatic test_tx_ack();
    logic [FW-1:0] got, exp_cap, msk;
    n_tests++; if (tx_ready[2] !== 1'b1) begin n_fail++; $display("FAIL txack_ready_before got=%b exp=1", tx_ready[2]); end
    enqueue(2, 32'h12345678);
    n_tests++; if (tx_ready[2] !== 1'b0) begin n_fail++; $display("FAIL txack_ready_full got=%b exp=0", tx_ready[2]); end
    do_scan(mk_frame(2, 0, 1, $urandom), FW, 1, '0, '0, got, exp_cap, msk);
    n_tests++; if (got[3:0] !== 4'b1001) begin n_fail++; $display("FAIL txack_header_bits got=%b exp=1001 (bit3..0)", got[3:0]); end
    n_tests++; if ((got & msk) !== (exp_cap & msk) || got[FW-1:CB+2] !== 32'h12345678) begin n_fail++; $display("FAIL txack_tdo got=%h exp=%h", got, exp_cap); end
    n_tests++; if (tx_ready[2] !== 1'b1 || tx_ready !== exp_txr()) begin n_fail++; $display("FAIL txack_pop got=%b exp=%b", tx_ready, exp_txr()); end
  endtask

  task automatic test_ack_empty();
    logic [FW-1:0] got, exp_cap, msk;
    do_scan(mk_frame(2, 0, 1, '0), FW, 1, '0, '0, got, exp_cap, msk);
    n_tests++; if (got[0] !== 1'b0) begin n_fail++; $display("FAIL ackempty_valid got=%b exp=0", got[0]); end
    enqueue(2, 32'hCAFE0001);
    n_tests++; if (tx_ready !== exp_txr()) begin n_fail++; $display("FAIL ackempty_enq got=%b exp=%b", tx_ready, exp_txr()); end
    do_scan(mk_frame(2, 0, 1, '0), FW, 1, '0, '0, got, exp_cap, msk);
    n_tests++; if (got[0] !== 1'b1 || got[FW-1:CB+2] !== 32'hCAFE0001) begin n_fail++; $display("FAIL ackempty_kept got=%h exp=%h", got, exp_cap); end
  endtask

  task automatic test_overflow();
    logic [FW-1:0] got, exp_cap, msk;
    rx_ready = 5'b11101;
    do_scan(mk_frame(1, 1, 0, 32'h0BAD0BAD), FW, 1, '0, '0, got, exp_cap, msk);
    n_tests++; if (rx_valid !== '0) begin n_fail++; $display("FAIL ovf_no_delivery got=%b exp=0", rx_valid); end
    n_tests++; if (cur_ch !== 3'd1) begin n_fail++; $display("FAIL ovf_cur_ch got=%0d exp=1", cur_ch); end
    rx_ready = '1;
    do_scan(mk_frame(1, 0, 0, '0), FW, 1, '0, '0, got, exp_cap, msk);
    n_tests++; if (got[1] !== 1'b1 || got[1] !== exp_cap[1]) begin n_fail++; $display("FAIL ovf_captured got=%b exp=1", got[1]); end
    do_scan(mk_frame(1, 0, 0, '0), FW, 1, '0, '0, got, exp_cap, msk);
    n_tests++; if (got[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_read_clear got=%b exp=0", got[1]); end
  endtask

  task automatic test_out_of_range();
    logic [FW-1:0] got, exp_cap, msk;
    for (int h = N; h < 8; h++) begin
      do_scan(mk_frame(h, 1, 0, $urandom), FW, 1, '0, '0, got, exp_cap, msk);
      n_tests++; if (rx_valid !== '0 || int'(cur_ch) != cur_m || cur_m != 1) begin n_fail++; $display("FAIL range_hch%0d got=%b/%0d exp=0/1", h, rx_valid, cur_ch); end
    end
  endtask

  task automatic test_enq_capture();
    logic [FW-1:0] got, exp_cap, msk;
    do_scan(mk_frame(3, 0, 0, '0), FW, 1, '0, '0, got, exp_cap, msk);
    do_scan(mk_frame(3, 0, 1, '0), FW, 1, 5'b01000, 32'h5A5A0003, got, exp_cap, msk);
    n_tests++; if (got[0] !== 1'b0 || tx_ready[3] !== 1'b0) begin n_fail++; $display("FAIL enqcap_pre_state got=%b/%b exp=0/0", got[0], tx_ready[3]); end
    do_scan(mk_frame(3, 0, 1, '0), FW, 1, '0, '0, got, exp_cap, msk);
    n_tests++; if (got[0] !== 1'b1 || got[FW-1:CB+2] !== 32'h5A5A0003 || tx_ready !== exp_txr()) begin n_fail++; $display("FAIL enqcap_follow got=%h/%b exp=%h/%b", got, tx_ready, exp_cap, exp_txr()); end
  endtask

  task automatic test_short_scan();
    logic [FW-1:0] got, exp_cap, msk;
    int cur_before;
    cur_before = cur_m;
    do_scan(mk_frame(0, 1, 0, 32'h7777AAAA), FW - 1, 1, '0, '0, got, exp_cap, msk);
    n_tests++; if (rx_valid !== exp_rxv || int'(cur_ch) != cur_m) begin n_fail++; $display("FAIL short_update got=%b/%0d exp=%b/%0d", rx_valid, cur_ch, exp_rxv, cur_m); end
`ifdef BSCAN_MUX_LEN_CHECK_EN
    n_tests++; if (rx_valid !== '0 || int'(cur_ch) != cur_before) begin n_fail++; $display("FAIL short_rejected got=%b/%0d exp=0/%0d", rx_valid, cur_ch, cur_before); end
`endif
    do_scan(mk_frame(cur_m, 0, 0, '0), FW, 1, '0, '0, got, exp_cap, msk);
    n_tests++; if ((got & msk) !== (exp_cap & msk)) begin n_fail++; $display("FAIL short_followup got=%h exp=%h", got & msk, exp_cap & msk); end
  endtask

  task automatic test_sel_low();
    logic [FW-1:0] got, exp_cap, msk;
    do_scan(mk_frame(4, 1, 1, $urandom), FW, 0, '0, '0, got, exp_cap, msk);
    n_tests++; if (rx_valid !== '0 || int'(cur_ch) != cur_m) begin n_fail++; $display("FAIL sellow_state got=%b/%0d exp=0/%0d", rx_valid, cur_ch, cur_m); end
    do_scan(mk_frame(cur_m, 0, 0, '0), FW, 1, '0, '0, got, exp_cap, msk);
    n_tests++; if ((got & msk) !== (exp_cap & msk)) begin n_fail++; $display("FAIL sellow_capture got=%h exp=%h", got & msk, exp_cap & msk); end
  endtask

  task automatic test_random();
    logic [FW-1:0] got, exp_cap, msk;
    int nb;
    for (int i = 0; i < 60; i++) begin
      rx_ready = N'($urandom);
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(FW - 4, FW + 3)) : FW;
      do_scan(mk_frame($urandom_range(0, 7), 1'($urandom), 1'($urandom), $urandom), nb,
              ($urandom_range(0, 7) != 0), N'($urandom), $urandom, got, exp_cap, msk);
      n_tests++; if ((got & msk) !== (exp_cap & msk)) begin n_fail++; $display("FAIL rand%0d_tdo got=%h exp=%h", i, got & msk, exp_cap & msk); end
      n_tests++; if (rx_valid !== exp_rxv) begin n_fail++; $display("FAIL rand%0d_rx_valid got=%b exp=%b", i, rx_valid, exp_rxv); end
      if (exp_rxv != '0) begin
        n_tests++; if (rx_data !== exp_rxd) begin n_fail++; $display("FAIL rand%0d_rx_data got=%h exp=%h", i, rx_data, exp_rxd); end
      end
      n_tests++; if (int'(cur_ch) != cur_m) begin n_fail++; $display("FAIL rand%0d_cur_ch got=%0d exp=%0d", i, cur_ch, cur_m); end
      n_tests++; if (tx_ready !== exp_txr()) begin n_fail++; $display("FAIL rand%0d_tx_ready got=%b exp=%b", i, tx_ready, exp_txr()); end
    end
  endtask

  task automatic test_reset_mid_shift();
    enqueue(4, 32'h44444444);
    sel = 1'b1; capture = 1'b1;
    tick();
    capture = 1'b0; shift = 1'b1; tdi = 1'b1;
    repeat (10) tick();
    #2 RST = 1'b1;
    #1;
    n_tests++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL midrst_tdo got=%b exp=0", tdo); end
    n_tests++; if (tx_ready !== '1) begin n_fail++; $display("FAIL midrst_tx_ready got=%b exp=11111", tx_ready); end
    n_tests++; if (cur_ch !== '0 || rx_valid !== '0) begin n_fail++; $display("FAIL midrst_cur_rx got=%0d/%b exp=0/0", cur_ch, rx_valid); end
    shift = 1'b0; sel = 1'b0; tdi = 1'b0;
    tick();
    RST = 1'b0;
    reset_model();
    tick();
  endtask

  initial begin
    test_reset();
    test_write_deliver();
    test_tx_ack();
    test_ack_empty();
    test_overflow();
    test_out_of_range();
    test_enq_capture();
    test_short_scan();
    test_sel_low();
    test_random();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
